// File: rtl/maze_neighbor_scanner_if.sv
// Request/response and maze-memory bus of the neighbour scanner.
// master: scanner side (drives memory strobes/address and the result).
// slave:  solver + memory side.
interface maze_neighbor_scanner_if #(
    parameter int COORD_W = 4
);
    logic               start;
    logic               mark;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               mem_rd;
    logic               mem_wr;
    logic [COORD_W-1:0] mem_x;
    logic [COORD_W-1:0] mem_y;
    logic               mem_din;
    logic               mem_dout;
    logic               busy;
    logic               done;
    logic [3:0]         open_mask;

    modport master (
        input  start, mark, cur_x, cur_y, mem_dout,
        output mem_rd, mem_wr, mem_x, mem_y, mem_din, busy, done, open_mask
    );

    modport slave (
        output start, mark, cur_x, cur_y, mem_dout,
        input  mem_rd, mem_wr, mem_x, mem_y, mem_din, busy, done, open_mask
    );
endinterface

// File: rtl/maze_neighbor_scanner.sv
// Maze neighbour scanner: optionally marks the current cell visited, then
// reads the up/right/down/left neighbours one at a time and returns a
// 4-bit open mask (1 = in bounds and not a wall) with a done pulse.
module maze_neighbor_scanner #(
    parameter int   COORD_W      = 4,
    parameter int   READ_LATENCY = 1,
    parameter logic WALL_VALUE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    maze_neighbor_scanner_if.master bus
);
    localparam logic [COORD_W-1:0] MAX_C = '1;
    localparam logic [1:0]         WAIT_LAST = 2'(READ_LATENCY - 2);

    typedef enum logic [2:0] {IDLE, MARK, ISSUE, WAIT, CAPTURE, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         dir, dir_nxt;
    logic [1:0]         wcnt, wcnt_nxt;
    logic [3:0]         acc, acc_nxt;
    logic [COORD_W-1:0] cx, cy;
    logic [COORD_W-1:0] addr_x_q, addr_y_q;
    logic [COORD_W-1:0] nb_x, nb_y;
    logic               nb_in;

    // Neighbour address for the current direction and whether it is on the grid.
    always_comb begin
        nb_x  = cx;
        nb_y  = cy;
        nb_in = 1'b0;
        case (dir)
            2'd0: begin nb_y = cy - COORD_W'(1); nb_in = (cy != '0);    end
            2'd1: begin nb_x = cx + COORD_W'(1); nb_in = (cx != MAX_C); end
            2'd2: begin nb_y = cy + COORD_W'(1); nb_in = (cy != MAX_C); end
            default: begin nb_x = cx - COORD_W'(1); nb_in = (cx != '0); end
        endcase
    end

    // Next-state logic: walk the four directions, skipping off-grid ones.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        wcnt_nxt  = wcnt;
        acc_nxt   = acc;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt   = '0;
                    dir_nxt   = '0;
                    state_nxt = bus.mark ? MARK : ISSUE;
                end
            end
            MARK: begin
                dir_nxt   = '0;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (nb_in) begin
                    wcnt_nxt  = '0;
                    state_nxt = (READ_LATENCY == 1) ? CAPTURE : WAIT;
                end else if (dir == 2'd3) begin
                    state_nxt = DONE;
                end else begin
                    dir_nxt = dir + 2'd1;
                end
            end
            WAIT: begin
                if (wcnt == WAIT_LAST) state_nxt = CAPTURE;
                else                   wcnt_nxt  = wcnt + 2'd1;
            end
            CAPTURE: begin
                acc_nxt[dir] = (bus.mem_dout != WALL_VALUE);
                if (dir == 2'd3) begin
                    state_nxt = DONE;
                end else begin
                    dir_nxt   = dir + 2'd1;
                    state_nxt = ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes and status decoded from state; the address falls back
    // to the last driven value so it stays put while idle or skipping.
    always_comb begin
        bus.mem_rd  = (state == ISSUE) && nb_in;
        bus.mem_wr  = (state == MARK);
        bus.mem_din = (state == MARK) ? WALL_VALUE : 1'b0;
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.mem_x   = addr_x_q;
        bus.mem_y   = addr_y_q;
        if (state == MARK) begin
            bus.mem_x = cx;
            bus.mem_y = cy;
        end else if ((state == ISSUE || state == WAIT || state == CAPTURE) && nb_in) begin
            bus.mem_x = nb_x;
            bus.mem_y = nb_y;
        end
    end

    // State, counters, captured cell, held address and published mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            dir           <= '0;
            wcnt          <= '0;
            acc           <= '0;
            cx            <= '0;
            cy            <= '0;
            addr_x_q      <= '0;
            addr_y_q      <= '0;
            bus.open_mask <= '0;
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            wcnt     <= wcnt_nxt;
            acc      <= acc_nxt;
            addr_x_q <= bus.mem_x;
            addr_y_q <= bus.mem_y;
            if (state == IDLE && bus.start) begin
                cx <= bus.cur_x;
                cy <= bus.cur_y;
            end
            // Publish on entry to DONE so the mask is valid alongside done.
            if (state_nxt == DONE) bus.open_mask <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_maze_neighbor_scanner.sv
// Bench: two scanners (read latency 1 and 3) run the same requests against
// their own behavioural maze memories; results are compared to a reference
// model derived from grid geometry and memory contents.
module tb_maze_neighbor_scanner;
    localparam int CW = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           start = 1'b0, mark = 1'b0;
    logic [CW-1:0]  cur_x = '0, cur_y = '0;
    logic           mem_load = 1'b0, mon_clr = 1'b0;
    logic           ref_mem [N][N];
    logic [3:0]     last_mask [2];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int RL = (g == 0) ? 1 : 3;

        maze_neighbor_scanner_if #(.COORD_W(CW)) bus ();

        maze_neighbor_scanner #(.COORD_W(CW), .READ_LATENCY(RL), .WALL_VALUE(1'b1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start = start;
        assign bus.mark  = mark;
        assign bus.cur_x = cur_x;
        assign bus.cur_y = cur_y;

        logic [16:0] outs;
        assign outs = {bus.mem_rd, bus.mem_wr, bus.mem_din, bus.busy, bus.done,
                       bus.open_mask, bus.mem_x, bus.mem_y};

        // Behavioural memory with READ_LATENCY-deep read pipe; junk when not read.
        logic          mem [N][N];
        logic [RL-1:0] pipe = '0;
        assign bus.mem_dout = pipe[RL-1];
        always @(posedge clk) begin
            if (mem_load) mem <= ref_mem;
            else if (bus.mem_wr) mem[bus.mem_x][bus.mem_y] <= bus.mem_din;
            pipe[0] <= bus.mem_rd ? mem[bus.mem_x][bus.mem_y] : 1'($urandom);
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end

        // Bus monitor: logs reads, writes, done pulses and busy cycles.
        int              rd_n = 0, wr_n = 0, done_n = 0, done_t = 0, busy_n = 0;
        logic [3:0][7:0]  rd_a = '0;
        logic [3:0][15:0] rd_t = '0;
        logic [7:0]       wr_a = '0;
        logic [3:0]       done_m = '0;
        logic             bad = 1'b0;
        always @(negedge clk) begin
            if (mon_clr) begin
                rd_n <= 0; wr_n <= 0; done_n <= 0; done_t <= 0; busy_n <= 0;
                rd_a <= '0; rd_t <= '0; wr_a <= '0; done_m <= '0; bad <= 1'b0;
            end else begin
                if (bus.mem_rd) begin
                    if (rd_n < 4) begin
                        rd_a[rd_n[1:0]] <= {bus.mem_x, bus.mem_y};
                        rd_t[rd_n[1:0]] <= 16'(cyc);
                    end
                    rd_n <= rd_n + 1;
                end
                if (bus.mem_wr) begin
                    wr_n <= wr_n + 1;
                    wr_a <= {bus.mem_x, bus.mem_y};
                    if (bus.mem_din !== 1'b1) bad <= 1'b1;
                end
                if (bus.mem_rd && bus.mem_wr) bad <= 1'b1;
                if (!bus.mem_wr && bus.mem_din !== 1'b0) bad <= 1'b1;
                if (bus.busy) busy_n <= busy_n + 1;
                if (bus.done) begin
                    done_n <= done_n + 1;
                    done_t <= cyc;
                    done_m <= bus.open_mask;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: in-bound neighbours in up/right/down/left order, each costing
    // 1+rl cycles if read and 1 if skipped; mark costs one extra cycle.
    task automatic check_scan(input int id, input int rl, input int k,
                              input int cx, input int cy, input bit mk,
                              input int o_rdn, input logic [3:0][7:0] o_ra,
                              input logic [3:0][15:0] o_rt, input int o_wrn,
                              input logic [7:0] o_wa, input int o_dn, input int o_dt,
                              input logic [3:0] o_dm, input int o_bn, input logic o_bad,
                              input logic [16:0] o_outs, input logic o_cell);
        int               dx [4] = '{0, 1, 0, -1};
        int               dy [4] = '{-1, 0, 1, 0};
        logic [3:0]       em = '0;
        int               n  = 0;
        int               t  = k + (mk ? 1 : 0);
        logic [3:0][7:0]  ea = '0;
        logic [3:0][15:0] et = '0;
        logic [7:0]       last = '0;
        string            p  = $sformatf("rl%0d_", rl);
        for (int d = 0; d < 4; d++) begin
            int nx = cx + dx[d];
            int ny = cy + dy[d];
            if (nx >= 0 && nx < N && ny >= 0 && ny < N) begin
                ea[n] = {4'(nx), 4'(ny)};
                et[n] = 16'(t);
                last  = {4'(nx), 4'(ny)};
                em[d] = (ref_mem[nx][ny] != 1'b1);
                n++;
                t += 1 + rl;
            end else begin
                t += 1;
            end
        end
        chk({p, "rd_count"}, 64'(o_rdn), 64'(n));
        chk({p, "rd_addr"},  o_ra, ea);
        chk({p, "rd_time"},  o_rt, et);
        chk({p, "wr_count"}, 64'(o_wrn), 64'(mk));
        chk({p, "wr_addr"},  o_wa, mk ? {4'(cx), 4'(cy)} : 8'h00);
        chk({p, "done_count"}, 64'(o_dn), 64'd1);
        chk({p, "done_lat"}, 64'(o_dt - k), 64'(t - k));
        chk({p, "done_mask"}, o_dm, em);
        chk({p, "busy_cycles"}, 64'(o_bn), 64'(t - k + 1));
        chk({p, "strobe_rules"}, o_bad, 1'b0);
        chk({p, "idle_outs"}, o_outs, {5'b0, em, last});
        chk({p, "cell_after"}, o_cell, mk ? 1'b1 : ref_mem[cx][cy]);
        last_mask[id] = em;
    endtask

    task automatic kick(input int cx, input int cy, input bit mk, output int k);
        @(negedge clk); #1 mem_load = 1'b1; mon_clr = 1'b1;
        @(negedge clk); #1 mem_load = 1'b0; mon_clr = 1'b0;
        start = 1'b1; mark = mk; cur_x = 4'(cx); cur_y = 4'(cy);
        k = cyc + 1;
        @(negedge clk); #1 start = 1'b0; mark = 1'b0;
        cur_x = 4'($urandom); cur_y = 4'($urandom);
    endtask

    task automatic run_scan(input int cx, input int cy, input bit mk, input bit poke);
        int k;
        kick(cx, cy, mk, k);
        if (poke) begin
            @(negedge clk); #1 start = 1'b1; mark = 1'b1; cur_x = 4'd0; cur_y = 4'd0;
            chk("poke_busy0", g_i[0].outs[13], 1'b1);
            chk("poke_busy1", g_i[1].outs[13], 1'b1);
            chk("poke_mask_held0", g_i[0].outs[11:8], last_mask[0]);
            chk("poke_mask_held1", g_i[1].outs[11:8], last_mask[1]);
            @(negedge clk); #1 start = 1'b0; mark = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            if (g_i[0].done_n > 0 && g_i[1].done_n > 0) break;
            @(negedge clk);
        end
        chk("scan_timeout", 64'(g_i[0].done_n > 0 && g_i[1].done_n > 0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check_scan(0, 1, k, cx, cy, mk, g_i[0].rd_n, g_i[0].rd_a, g_i[0].rd_t,
                   g_i[0].wr_n, g_i[0].wr_a, g_i[0].done_n, g_i[0].done_t,
                   g_i[0].done_m, g_i[0].busy_n, g_i[0].bad, g_i[0].outs,
                   g_i[0].mem[cx][cy]);
        check_scan(1, 3, k, cx, cy, mk, g_i[1].rd_n, g_i[1].rd_a, g_i[1].rd_t,
                   g_i[1].wr_n, g_i[1].wr_a, g_i[1].done_n, g_i[1].done_t,
                   g_i[1].done_m, g_i[1].busy_n, g_i[1].bad, g_i[1].outs,
                   g_i[1].mem[cx][cy]);
        if (mk) ref_mem[cx][cy] = 1'b1;
    endtask

    function automatic int pick();
        int s = $urandom_range(0, 3);
        if (s == 0) return 0;
        if (s == 1) return N - 1;
        return $urandom_range(0, N - 1);
    endfunction

    task automatic fill(input bit rnd);
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
                ref_mem[x][y] = rnd ? 1'($urandom) : 1'b0;
    endtask

    initial begin
        int k;
        last_mask[0] = '0;
        last_mask[1] = '0;
        fill(1'b0);

        // Reset values
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs0", g_i[0].outs, 17'h0);
        chk("reset_outs1", g_i[1].outs, 17'h0);
        #1 rst = 1'b1;

        // Interior cell: open up/down, walls right/left
        fill(1'b1);
        ref_mem[5][3] = 1'b0; ref_mem[6][4] = 1'b1;
        ref_mem[5][5] = 1'b0; ref_mem[4][4] = 1'b1;
        run_scan(5, 4, 1'b0, 1'b0);

        // Corner (0,0) with mark
        fill(1'b1);
        ref_mem[0][0] = 1'b0; ref_mem[1][0] = 1'b0; ref_mem[0][1] = 1'b0;
        run_scan(0, 0, 1'b1, 1'b0);

        // Corner (15,15), all open
        fill(1'b0);
        run_scan(15, 15, 1'b0, 1'b0);

        // Start while busy is ignored
        fill(1'b1);
        run_scan(8, 8, 1'b0, 1'b1);

        // Reset during the second read aborts the scan
        fill(1'b1);
        kick(7, 9, 1'b0, k);
        for (int i = 0; i < 40 && g_i[0].rd_n < 2; i++) @(negedge clk);
        chk("second_read_seen", 64'(g_i[0].rd_n >= 2), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_outs0", g_i[0].outs, 17'h0);
        chk("abort_outs1", g_i[1].outs, 17'h0);
        @(negedge clk); #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done0", 64'(g_i[0].done_n), 64'd0);
        chk("abort_no_done1", 64'(g_i[1].done_n), 64'd0);
        chk("abort_idle_outs0", g_i[0].outs, 17'h0);
        chk("abort_idle_outs1", g_i[1].outs, 17'h0);
        last_mask[0] = '0;
        last_mask[1] = '0;
        run_scan(7, 9, 1'b0, 1'b0);

        // Randomized scans over random mazes, biased toward the edges
        for (int r = 0; r < 10; r++) begin
            int cx, cy;
            fill(1'b1);
            cx = pick();
            cy = pick();
            run_scan(cx, cy, 1'($urandom), 1'(r == 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/maze_neighbor_scanner.md
Name: maze_neighbor_scanner

Overview:
Requester-side client of the 16x16 maze bit memory (1 = wall/visited, 0 = open). On a start pulse it can mark the current cell visited with one write. It then issues sequential single-bit reads for the four neighbours of (cur_x, cur_y) and returns a 4-bit open mask with a done pulse. It sits between the maze-solver FSM and the maze memory and owns all rd/wr/address generation toward the memory.

Parameters:
COORD_W, 4, coordinate width; grid is 2^COORD_W cells per side.
READ_LATENCY, 1, cycles from the mem_rd cycle to a valid mem_dout sample (range 1..3).
WALL_VALUE, 1, memory bit value meaning blocked.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
mark  input  1  sampled with start; 1 = write WALL_VALUE to the current cell before the scan.
cur_x  input  COORD_W  current cell x; captured at start.
cur_y  input  COORD_W  current cell y; captured at start.
mem_rd  output  1  memory read strobe.
mem_wr  output  1  memory write strobe.
mem_x  output  COORD_W  memory x address.
mem_y  output  COORD_W  memory y address.
mem_din  output  1  write data.
mem_dout  input  1  read data.
busy  output  1  high whenever the FSM is not in IDLE.
done  output  1  one-cycle pulse when open_mask is valid.
open_mask  output  4  bit0 up (y-1), bit1 right (x+1), bit2 down (y+1), bit3 left (x-1); 1 = in-bounds and not wall.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_rd, mem_wr, mem_din, done, busy = 0; mem_x, mem_y, open_mask = 0; captured coordinates = 0.
- States: IDLE, MARK, ISSUE, WAIT, CAPTURE, DONE. Direction counter dir runs 0..3 in the order up, right, down, left.
- IDLE: start=1 at an edge captures cur_x, cur_y, mark and clears the mask accumulator. Next state is MARK if mark=1, else ISSUE with dir=0.
- MARK (1 cycle): mem_wr=1, mem_din=WALL_VALUE, address = captured cell. Next state is ISSUE with dir=0.
- ISSUE (1 cycle):
  - Neighbour in bounds: mem_rd=1, address = neighbour; go to WAIT, or to CAPTURE when READ_LATENCY=1.
  - Neighbour out of bounds (x=0 left, x=max right, y=0 up, y=max down): no strobe, mask bit = 0; advance dir, or go to DONE after dir=3.
- No coordinate wrap-around: out-of-bounds neighbours are never addressed.
- WAIT: holds READ_LATENCY-1 cycles; mem_rd=0; address held.
- CAPTURE (1 cycle): mask[dir] = (mem_dout != WALL_VALUE). Advance dir to ISSUE, or go to DONE after dir=3.
- DONE (1 cycle): open_mask <= accumulator; done=1; busy=1; next state IDLE.
- open_mask holds its value until the next DONE. It is not cleared at start.
- Latency, interior cell, mark=0, READ_LATENCY=1: start sampled at edge k; reads in cycles k+1, k+3, k+5, k+7; done high between edges k+8 and k+9.
  - mark=1 adds 1 cycle.
  - Each out-of-bounds neighbour costs 1 cycle instead of 1+READ_LATENCY.
- mem_rd and mem_wr are never high in the same cycle. Each strobe is high for exactly one cycle per access.
- mem_x/mem_y are held at the last address while idle. mem_din=0 except in MARK.
- start while busy (including the DONE cycle) is ignored: no queueing, no restart.
- Reset asserted mid-scan aborts immediately to the reset values. No partial mask is published.

Test Plan:
- Interior cell, open up/down, wall right/left: memory cells (5,3)=0, (6,4)=1, (5,5)=0, (4,4)=1; start with cur=(5,4), mark=0 -> four reads at (5,3),(6,4),(5,5),(4,4) on alternate cycles; done at k+8; open_mask=4'b0101; mem_wr never asserted.
- Corner (0,0), mark=1, memory (1,0)=0, (0,1)=0 -> write (0,0) with mem_din=1; reads only (1,0),(0,1); open_mask=4'b0110; done 7 cycles after start; memory (0,0)=1 afterwards.
- Corner (15,15), all memory 0 -> reads only (15,14),(14,15); open_mask=4'b1001; no address 0 ever driven on a read.
- start pulsed again 3 cycles into a scan with different coordinates -> ignored; result matches the first request; busy stays high until IDLE.
- rst driven low during the second read, then released -> outputs at reset values asynchronously; open_mask=0; no done pulse; a new start rescans correctly.
- READ_LATENCY=3, interior cell -> reads spaced 4 cycles apart; mem_dout sampled 3 cycles after each mem_rd; done 16 cycles after start.
